// File: rtl/heartbeat_monitor.sv
// Heartbeat checker: measures each period and high time, publishes the last
// measurement pair, and holds the first fault until it is cleared.
module heartbeat_monitor #(
  parameter int unsigned PERIOD_MIN = 11_880_000,
  parameter int unsigned PERIOD_MAX = 12_120_000,
  parameter int unsigned HIGH_MIN   = 2_376_000,
  parameter int unsigned HIGH_MAX   = 2_424_000,
  localparam int unsigned CW        = $clog2(PERIOD_MAX + 2)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_heartbeat,
  input  logic          i_clear_fault,
  output logic [CW-1:0] o_period,
  output logic [CW-1:0] o_high_time,
  output logic          o_meas_valid,
  output logic          o_fault,
  output logic [1:0]    o_fault_code,
  output logic          o_alive
);

  typedef enum logic [1:0] {SYNC = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_e;

  localparam logic [1:0] CODE_NONE  = 2'd0;
  localparam logic [1:0] CODE_SHORT = 2'd1;
  localparam logic [1:0] CODE_LONG  = 2'd2;
  localparam logic [1:0] CODE_HIGH  = 2'd3;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e        state_q, state_d;
  logic          hb_q;
  logic [CW-1:0] per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d;
  logic [CW-1:0] hi_meas_q, hi_meas_d, per_meas_q, per_meas_d;
  logic          hi_ok_q, hi_ok_d, meas_pend_q, meas_pend_d, force_q, force_d;
  logic [1:0]    pend_code_q, pend_code_d;
  logic [CW-1:0] period_q, period_d, high_time_q, high_time_d;
  logic          meas_valid_q, meas_valid_d, fault_q, fault_d, alive_q, alive_d;
  logic [1:0]    fault_code_q, fault_code_d;
  logic          rise, fall, hi_in_window;

  assign rise         = i_heartbeat & ~hb_q;
  assign fall         = ~i_heartbeat & hb_q;
  assign hi_in_window = (hi_cnt_q >= CW'(HIGH_MIN)) && (hi_cnt_q <= CW'(HIGH_MAX));

  // Measurement FSM; detected faults go to pend_code and are published one cycle later.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    per_cnt_d   = per_cnt_q;
    hi_cnt_d    = hi_cnt_q;
    hi_meas_d   = hi_meas_q;
    hi_ok_d     = hi_ok_q;
    per_meas_d  = per_meas_q;
    meas_pend_d = 1'b0;
    pend_code_d = CODE_NONE;

    unique case (state_q)
      SYNC: if (rise) begin
        per_cnt_d = CW'(1);
        hi_cnt_d  = CW'(1);
        state_d   = HIGH;
      end
      HIGH: begin
        per_cnt_d = sat_inc(per_cnt_q);
        hi_cnt_d  = sat_inc(hi_cnt_q);
        if (fall) begin
          hi_meas_d = hi_cnt_q;
          hi_ok_d   = hi_in_window;
          if (!hi_in_window) pend_code_d = CODE_HIGH;
          state_d   = LOW;
        end
      end
      LOW: begin
        per_cnt_d = sat_inc(per_cnt_q);
        if (rise) begin
          per_meas_d  = per_cnt_q;
          meas_pend_d = 1'b1;
          if (per_cnt_q < CW'(PERIOD_MIN)) pend_code_d = CODE_SHORT;
          per_cnt_d   = CW'(1);
          hi_cnt_d    = CW'(1);
          state_d     = HIGH;
        end
      end
      default: state_d = SYNC;
    endcase

    if (state_q != SYNC && per_cnt_q == CW'(PERIOD_MAX) && !rise) begin
      if (pend_code_d < CODE_LONG) pend_code_d = CODE_LONG;
      per_cnt_d = '0;
      hi_cnt_d  = '0;
      state_d   = SYNC;
    end
  end

  // A clear that coincides with a fresh detection must not drop the flag, and
  // must let the new code replace the old one when it lands a cycle later.
  always_comb begin
    period_d     = period_q;
    high_time_d  = high_time_q;
    meas_valid_d = meas_pend_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    alive_d      = alive_q;
    force_d      = i_clear_fault && (pend_code_d != CODE_NONE);

    if (meas_pend_q) begin
      period_d    = per_meas_q;
      high_time_d = hi_meas_q;
    end

    if (pend_code_q != CODE_NONE)  alive_d = 1'b0;
    else if (meas_pend_q)          alive_d = hi_ok_q & ~fault_q;

    if (pend_code_q != CODE_NONE) begin
      fault_d = 1'b1;
      if (!fault_q || i_clear_fault || force_q) fault_code_d = pend_code_q;
    end else if (i_clear_fault && pend_code_d == CODE_NONE) begin
      fault_d      = 1'b0;
      fault_code_d = CODE_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SYNC;
      hb_q         <= 1'b0;
      per_cnt_q    <= '0;
      hi_cnt_q     <= '0;
      hi_meas_q    <= '0;
      hi_ok_q      <= 1'b0;
      per_meas_q   <= '0;
      meas_pend_q  <= 1'b0;
      pend_code_q  <= CODE_NONE;
      force_q      <= 1'b0;
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= CODE_NONE;
      alive_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      hb_q         <= i_heartbeat;
      per_cnt_q    <= per_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      hi_meas_q    <= hi_meas_d;
      hi_ok_q      <= hi_ok_d;
      per_meas_q   <= per_meas_d;
      meas_pend_q  <= meas_pend_d;
      pend_code_q  <= pend_code_d;
      force_q      <= force_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      meas_valid_q <= meas_valid_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      alive_q      <= alive_d;
    end
  end

  assign o_period     = period_q;
  assign o_high_time  = high_time_q;
  assign o_meas_valid = meas_valid_q;
  assign o_fault      = fault_q;
  assign o_fault_code = fault_code_q;
  assign o_alive      = alive_q;

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Self-checking bench for heartbeat_monitor: directed table, corner sequences
// and random pulse trains against an event-timestamp reference model.
module tb_heartbeat_monitor;

  localparam int PMIN = 90;
  localparam int PMAX = 110;
  localparam int HMIN = 18;
  localparam int HMAX = 22;
  localparam int CW   = $clog2(PMAX + 2);

  logic          clk = 1'b0;
  logic          rst, hb, clr;
  logic [CW-1:0] o_period, o_high_time;
  logic          o_meas_valid, o_fault, o_alive;
  logic [1:0]    o_fault_code;

  int total = 0;
  int bad   = 0;

  heartbeat_monitor #(
    .PERIOD_MIN(PMIN), .PERIOD_MAX(PMAX), .HIGH_MIN(HMIN), .HIGH_MAX(HMAX)
  ) dut (
    .clk(clk), .reset(rst), .i_heartbeat(hb), .i_clear_fault(clr),
    .o_period(o_period), .o_high_time(o_high_time), .o_meas_valid(o_meas_valid),
    .o_fault(o_fault), .o_fault_code(o_fault_code), .o_alive(o_alive)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: tracks the time of the last rise and applies the rules
  // to whole events (rise, fall, elapsed time) rather than counters.
  int m_prev, m_track, m_rise_t, m_hi_meas, m_hi_ok, m_cyc;
  int p_meas, p_per, p_hi, p_hi_ok, p_code, p_force;
  int e_per, e_hi, e_valid, e_fault, e_code, e_alive;

  task automatic model_step(input int x, input int c, input int r);
    int rise, fall, age, det, meas, per;
    if (r != 0) begin
      {m_prev, m_track, m_rise_t, m_hi_meas, m_hi_ok} = '0;
      {p_meas, p_per, p_hi, p_hi_ok, p_code, p_force} = '0;
      {e_per, e_hi, e_valid, e_fault, e_code, e_alive} = '0;
      m_cyc++;
      return;
    end
    rise = (x != 0 && m_prev == 0);
    fall = (x == 0 && m_prev != 0);
    det = 0; meas = 0; per = 0;
    if (m_track != 0) begin
      age = m_cyc - m_rise_t;
      if (rise != 0) begin
        meas = 1; per = age;
        if (age < PMIN) det = 1;
        m_rise_t = m_cyc;
      end else begin
        if (fall != 0) begin
          m_hi_meas = age;
          m_hi_ok   = (age >= HMIN && age <= HMAX);
          if (m_hi_ok == 0) det = 3;
        end
        if (age == PMAX) begin
          if (det < 2) det = 2;
          m_track = 0;
        end
      end
    end else if (rise != 0) begin
      m_track = 1; m_rise_t = m_cyc;
    end
    e_valid = p_meas;
    if (p_meas != 0) begin e_per = p_per; e_hi = p_hi; end
    if (p_code != 0)      e_alive = 0;
    else if (p_meas != 0) e_alive = (p_hi_ok != 0 && e_fault == 0);
    if (p_code != 0) begin
      if (e_fault == 0 || c != 0 || p_force != 0) e_code = p_code;
      e_fault = 1;
    end else if (c != 0 && det == 0) begin
      e_fault = 0; e_code = 0;
    end
    p_meas = meas; p_per = per; p_hi = m_hi_meas; p_hi_ok = m_hi_ok;
    p_code = det; p_force = (c != 0 && det != 0);
    m_prev = x; m_cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step(int'(hb), int'(clr), int'(rst));
    check("model", {o_period, o_high_time, o_meas_valid, o_fault, o_fault_code, o_alive},
          {CW'(e_per), CW'(e_hi), e_valid[0], e_fault[0], e_code[1:0], e_alive[0]});
  endtask

  task automatic pulse(input int high, input int period);
    for (int k = 0; k < period; k++) begin
      hb = (k < high);
      step();
    end
  endtask

  typedef struct {
    int high; int period; int clr_k; bit chk;
    int e_per; int e_hi; bit e_fault; int e_code; bit e_alive;
  } vec_t;

  vec_t tbl[13];
  int   vcnt;

  initial begin
    // Each row drives one pulse; its checks describe the period that ended at its rise.
    tbl[0]  = '{20, 100, -1, 1'b0,   0,  0, 1'b0, 0, 1'b0};
    tbl[1]  = '{20, 100, -1, 1'b1, 100, 20, 1'b0, 0, 1'b1};
    tbl[2]  = '{20,  85, -1, 1'b1, 100, 20, 1'b0, 0, 1'b1};
    tbl[3]  = '{20, 100, -1, 1'b1,  85, 20, 1'b1, 1, 1'b0};
    tbl[4]  = '{20, 100, 50, 1'b1, 100, 20, 1'b1, 1, 1'b0};
    tbl[5]  = '{25, 100, -1, 1'b1, 100, 20, 1'b0, 0, 1'b1};
    tbl[6]  = '{20,  85, -1, 1'b1, 100, 25, 1'b1, 3, 1'b0};
    tbl[7]  = '{20, 100,  0, 1'b1,  85, 20, 1'b1, 1, 1'b0};
    tbl[8]  = '{ 1, 100, 50, 1'b1, 100, 20, 1'b1, 1, 1'b0};
    tbl[9]  = '{20, 110, -1, 1'b1, 100,  1, 1'b0, 0, 1'b0};
    tbl[10] = '{18,  90, -1, 1'b1, 110, 20, 1'b0, 0, 1'b1};
    tbl[11] = '{22, 100, -1, 1'b1,  90, 18, 1'b0, 0, 1'b1};
    tbl[12] = '{20, 100, -1, 1'b1, 100, 22, 1'b0, 0, 1'b1};

    m_cyc = 0;
    hb = 1'b0; clr = 1'b0; rst = 1'b1;
    step(); step();
    check("reset_outputs", {o_period, o_high_time, o_meas_valid, o_fault, o_fault_code, o_alive}, 0);
    rst = 1'b0;

    repeat (150) step();
    check("idle_low_no_fault", o_fault, 0);

    for (int i = 0; i < 13; i++) begin
      for (int k = 0; k < tbl[i].period; k++) begin
        hb  = (k < tbl[i].high);
        clr = (k == tbl[i].clr_k);
        step();
        if (k == 1 && tbl[i].chk) begin
          check($sformatf("tbl%0d_valid", i), o_meas_valid, 1);
          check($sformatf("tbl%0d_period", i), o_period, tbl[i].e_per);
          check($sformatf("tbl%0d_high", i), o_high_time, tbl[i].e_hi);
          check($sformatf("tbl%0d_fault", i), o_fault, tbl[i].e_fault);
          check($sformatf("tbl%0d_code", i), o_fault_code, tbl[i].e_code);
          check($sformatf("tbl%0d_alive", i), o_alive, tbl[i].e_alive);
        end
      end
    end
    clr = 1'b0;

    // Stuck high after a rise: fault appears PMAX+1 cycles after the rise.
    hb = 1'b1;
    for (int j = 0; j <= PMAX + 1; j++) begin
      step();
      if (j == 1)        check("stuck_last_meas", o_period, 100);
      if (j == PMAX)     check("stuck_not_yet", o_fault, 0);
      if (j == PMAX + 1) begin
        check("stuck_fault", o_fault, 1);
        check("stuck_code", o_fault_code, 2);
        check("stuck_alive", o_alive, 0);
        check("stuck_no_valid", o_meas_valid, 0);
      end
    end
    hb = 1'b0;
    repeat (30) step();
    pulse(20, 100);
    pulse(20, 100);
    hb = 1'b1;
    step(); step();
    check("restart_valid", o_meas_valid, 1);
    check("restart_period", o_period, 100);
    check("restart_code_held", o_fault_code, 2);

    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clear_alone_fault", o_fault, 0);
    check("clear_alone_code", o_fault_code, 0);

    hb = 1'b0;
    repeat (100) step();

    // Reset while the line is high, ten cycles after a rise.
    vcnt = 0;
    for (int k = 0; k < 100; k++) begin
      hb  = (k < 20);
      rst = (k == 10);
      step();
      if (k == 10)
        check("midhigh_reset_outputs",
              {o_period, o_high_time, o_meas_valid, o_fault, o_fault_code, o_alive}, 0);
      if (k > 10 && o_meas_valid) vcnt++;
    end
    rst = 1'b0;
    check("midhigh_no_valid", vcnt, 0);
    pulse(20, 100);

    for (int n = 0; n < 80; n++) begin
      int per;
      int hi;
      if (n % 20 == 19) begin
        hb = 1'($urandom_range(0, 1)); clr = 1'b0; rst = 1'b0;
        repeat (130) step();
      end else begin
        per = int'($urandom_range(80, 118));
        hi  = ($urandom_range(0, 9) == 0) ? 1 : int'($urandom_range(14, 26));
        for (int k = 0; k < per; k++) begin
          hb  = (k < hi);
          clr = ($urandom_range(0, 63) == 0);
          rst = ($urandom_range(0, 999) == 0);
          step();
        end
      end
    end
    rst = 1'b0; clr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
